// File: rtl/core_pkg.sv
// Shared core definitions: reset vector, NOP encoding, fetch FSM states and
// the execute-stage control word layout.
package core_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_FETCH = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        ALU_SRC_REG = 2'd0,
        ALU_SRC_IMM = 2'd1,
        ALU_SRC_PC  = 2'd2
    } alu_src_e;

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        alu_src_e   alu_src;
        logic [3:0] alu_op;
    } ex_control_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO holding fetched instruction words together with their PCs.
module fetch_fifo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_instr,
    input  logic        pop,
    output logic [31:0] head_pc,
    output logic [31:0] head_instr,
    output logic [1:0]  count
);

    logic [31:0] pc_mem    [2];
    logic [31:0] instr_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word requests, buffers in-order responses
// and feeds the IF/ID register; branches flush and drain stale responses.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch,
    input  logic [31:0] branch_address,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        misaligned
);

    fetch_state_e state, state_next;
    logic [31:0]  fetch_pc;
    logic [31:0]  rsp_pc;
    logic [1:0]   outstanding, outstanding_next;
    logic [1:0]   stale, stale_next;
    logic         grant;
    logic         live_rsp;
    logic         load_en;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_empty;
    logic [1:0]   fifo_count;
    logic [31:0]  head_pc;
    logic [31:0]  head_instr;

    // In-flight plus buffered words never exceed two, so the FIFO cannot overflow.
    assign imem_req  = (state == FS_FETCH) &&
                       (({1'b0, outstanding} + {1'b0, fifo_count}) < 3'd2);
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    assign outstanding_next = outstanding + {1'b0, grant} - {1'b0, imem_rvalid};

    assign live_rsp   = imem_rvalid && (state == FS_FETCH) && !branch;
    assign load_en    = !stall || !if_id_valid;
    assign fifo_empty = (fifo_count == 2'd0);
    assign fifo_pop   = load_en && !fifo_empty;
    // With an empty FIFO and a free IF/ID register the response bypasses the FIFO.
    assign fifo_push  = live_rsp && !(load_en && fifo_empty);

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (branch),
        .push       (fifo_push),
        .push_pc    (rsp_pc),
        .push_instr (imem_rdata),
        .pop        (fifo_pop),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FS_BOOT;
            stale       <= 2'd0;
            outstanding <= 2'd0;
        end else begin
            state       <= state_next;
            stale       <= stale_next;
            outstanding <= outstanding_next;
        end
    end

    always_comb begin
        state_next = state;
        stale_next = stale;
        case (state)
            FS_BOOT: state_next = FS_FETCH;
            FS_FETCH: begin
                if (branch) begin
                    stale_next = outstanding_next;
                    if (outstanding_next != 2'd0) state_next = FS_DRAIN;
                end
            end
            FS_DRAIN: begin
                if (imem_rvalid && stale != 2'd0) begin
                    stale_next = stale - 2'd1;
                    if (stale == 2'd1) state_next = FS_FETCH;
                end
            end
            default: state_next = FS_BOOT;
        endcase
    end

    // rsp_pc is the PC of the next live response, realigned on every redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            rsp_pc     <= RESET_PC;
            misaligned <= 1'b0;
        end else begin
            misaligned <= branch && (branch_address[1:0] != 2'b00);
            if (branch) begin
                fetch_pc <= word_align(branch_address);
                rsp_pc   <= word_align(branch_address);
            end else begin
                if (grant)    fetch_pc <= fetch_pc + 32'd4;
                if (live_rsp) rsp_pc   <= rsp_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'h0000_0000;
            if_id_instr <= NOP_INSTR;
        end else if (branch) begin
            if_id_valid <= 1'b0;
        end else if (load_en) begin
            if (!fifo_empty) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= head_pc;
                if_id_instr <= head_instr;
            end else if (live_rsp) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= rsp_pc;
                if_id_instr <= imem_rdata;
            end else begin
                if_id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order, fixed-latency memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branch_address = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        misaligned;

    int n_checks = 0;
    int n_pass   = 0;
    int lat      = 1;

    logic        p_v [4];
    logic [31:0] p_a [4];

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .branch         (branch),
        .branch_address (branch_address),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .misaligned     (misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA000_0000;
    endfunction

    // Memory returns each granted word exactly lat cycles later, in order.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                p_v[i] <= 1'b0;
                p_a[i] <= 32'h0;
            end
        end else begin
            p_v[0] <= imem_req && imem_gnt;
            p_a[0] <= imem_addr;
            for (int i = 1; i < 4; i++) begin
                p_v[i] <= p_v[i-1];
                p_a[i] <= p_a[i-1];
            end
        end
    end

    assign imem_rvalid = p_v[lat-1];
    assign imem_rdata  = instr_of(p_a[lat-1]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(imem_req),    32'd0);
        check({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        check({tag, "_pc"},    if_id_pc,         32'h0);
        check({tag, "_instr"}, if_id_instr,      32'h0000_0013);
        check({tag, "_mis"},   32'(misaligned),  32'd0);
    endtask

    // Returns at the negedge where reset is released; the DUT is then in BOOT.
    task automatic do_reset(input int l);
        rst_n  = 1'b0;
        branch = 1'b0;
        stall  = 1'b0;
        @(negedge clk);
        lat = l;
        check_reset_outputs("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        // Streaming with a 1-cycle memory.
        do_reset(1);
        check("boot_req", 32'(imem_req), 32'd0);
        cyc(1);
        check("s1_req_n1", 32'(imem_req), 32'd1);
        check("s1_addr_n1", imem_addr, 32'h0);
        cyc(1);
        check("s1_addr_n2", imem_addr, 32'h4);
        check("s1_valid_n2", 32'(if_id_valid), 32'd0);
        for (int k = 3; k <= 6; k++) begin
            cyc(1);
            check("s1_addr", imem_addr, 32'(4 * (k - 1)));
            check("s1_pc", if_id_pc, 32'(4 * (k - 3)));
            check("s1_instr", if_id_instr, instr_of(32'(4 * (k - 3))));
        end

        // Stall for three edges while streaming.
        stall = 1'b1;
        for (int k = 7; k <= 9; k++) begin
            cyc(1);
            check("st_pc_frozen", if_id_pc, 32'hC);
            check("st_instr_frozen", if_id_instr, instr_of(32'hC));
            check("st_req_low", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        cyc(1);
        check("st_pc_n10", if_id_pc, 32'h10);
        check("st_req_n10", 32'(imem_req), 32'd1);
        check("st_addr_n10", imem_addr, 32'h18);
        for (int k = 11; k <= 13; k++) begin
            cyc(1);
            check("st_pc_after", if_id_pc, 32'(4 * (k - 6)));
            check("st_valid_after", 32'(if_id_valid), 32'd1);
        end

        // Branch with two requests outstanding, 3-cycle memory.
        do_reset(3);
        cyc(1);
        check("br_addr_n1", imem_addr, 32'h0);
        cyc(1);
        check("br_addr_n2", imem_addr, 32'h4);
        cyc(1);
        check("br_req_n3", 32'(imem_req), 32'd0);
        branch = 1'b1;
        branch_address = 32'h0000_0100;
        cyc(1);
        branch = 1'b0;
        check("br_req_drain1", 32'(imem_req), 32'd0);
        check("br_valid_drain1", 32'(if_id_valid), 32'd0);
        cyc(1);
        check("br_req_drain2", 32'(imem_req), 32'd0);
        check("br_valid_drain2", 32'(if_id_valid), 32'd0);
        cyc(1);
        check("br_req_resume", 32'(imem_req), 32'd1);
        check("br_addr_resume", imem_addr, 32'h100);
        check("br_valid_resume", 32'(if_id_valid), 32'd0);
        cyc(4);
        check("br_valid_first", 32'(if_id_valid), 32'd1);
        check("br_pc_first", if_id_pc, 32'h100);
        check("br_instr_first", if_id_instr, instr_of(32'h100));

        // Branch coincident with grant and rvalid, 1-cycle memory.
        do_reset(1);
        cyc(3);
        check("co_addr_n3", imem_addr, 32'h8);
        check("co_pc_n3", if_id_pc, 32'h0);
        branch = 1'b1;
        branch_address = 32'h0000_0200;
        cyc(1);
        branch = 1'b0;
        check("co_valid_n4", 32'(if_id_valid), 32'd0);
        check("co_req_n4", 32'(imem_req), 32'd0);
        cyc(1);
        check("co_addr_n5", imem_addr, 32'h200);
        cyc(1);
        check("co_valid_n6", 32'(if_id_valid), 32'd0);
        cyc(1);
        check("co_valid_n7", 32'(if_id_valid), 32'd1);
        check("co_pc_n7", if_id_pc, 32'h200);

        // Misaligned target.
        branch = 1'b1;
        branch_address = 32'h0000_0206;
        cyc(1);
        branch = 1'b0;
        check("mis_pulse", 32'(misaligned), 32'd1);
        check("mis_valid", 32'(if_id_valid), 32'd0);
        cyc(1);
        check("mis_clear", 32'(misaligned), 32'd0);
        check("mis_addr", imem_addr, 32'h204);
        cyc(2);
        check("mis_pc", if_id_pc, 32'h204);

        // Address wrap at the top of memory.
        branch = 1'b1;
        branch_address = 32'hFFFF_FFFC;
        cyc(1);
        branch = 1'b0;
        cyc(1);
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        cyc(1);
        check("wrap_addr_zero", imem_addr, 32'h0);
        cyc(1);
        check("wrap_pc_top", if_id_pc, 32'hFFFF_FFFC);
        check("wrap_instr_top", if_id_instr, instr_of(32'hFFFF_FFFC));
        cyc(1);
        check("wrap_pc_zero", if_id_pc, 32'h0);
        check("wrap_valid", 32'(if_id_valid), 32'd1);

        // Asynchronous reset mid-stream, observed before any clock edge.
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        check("rerun_addr", imem_addr, 32'h0);
        check("rerun_req", 32'(imem_req), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port branch  input  1  redirect request from the execute stage, valid for one cycle.
REQ-005 SHALL have port branch_address  input  32  redirect target (pc+imm from the execute stage).
REQ-006 SHALL have port stall  input  1  decode stage cannot accept; hold the IF/ID outputs.
REQ-007 SHALL have port imem_req  output  1  instruction memory request valid.
REQ-008 SHALL have port imem_addr  output  32  request address, word aligned.
REQ-009 SHALL have port imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-010 SHALL have port imem_rvalid  input  1  response data valid; responses return in order, at least 1 cycle after grant.
REQ-011 SHALL have port imem_rdata  input  32  instruction word.
REQ-012 SHALL have port if_id_valid  output  1  IF/ID register holds a live instruction.
REQ-013 SHALL have port if_id_pc  output  32  PC of the held instruction.
REQ-014 SHALL have port if_id_instr  output  32  the held instruction.
REQ-015 SHALL have port misaligned  output  1  one-cycle pulse when branch_address[1:0] != 0.

Function
REQ-016 SHALL implement an FSM with states BOOT, FETCH and DRAIN; BOOT (one cycle after reset release) SHALL transition to FETCH.
REQ-017 SHALL issue imem_req only in FETCH, and only while (outstanding + buffered) < 2.
REQ-018 SHALL drive imem_addr = fetch PC and advance the fetch PC by 4 (mod 2^32, wrapping at 32'hFFFF_FFFC to 0) only on imem_req & imem_gnt.
REQ-019 SHALL track outstanding requests with a 2-bit counter: +1 on grant, -1 on rvalid, net 0 on both in the same cycle.
REQ-020 SHALL hold each live response with its PC in a 2-entry FIFO; the FIFO SHALL never overflow, which REQ-017 guarantees.
REQ-021 SHALL load the IF/ID register from the FIFO head when !stall or !if_id_valid; otherwise it SHALL hold if_id_* unchanged.
REQ-022 SHALL give a response arriving with an empty FIFO and an unstalled IF/ID register a latency of exactly 1 cycle (rvalid edge -> if_id_valid).
REQ-023 SHALL, on branch=1: set fetch PC = {branch_address[31:2],2'b00}, flush the FIFO, clear if_id_valid next cycle (overriding stall), and load a stale counter with all outstanding requests, including one granted that same cycle.
REQ-024 SHALL enter DRAIN when the stale count is nonzero, and otherwise stay in FETCH.
REQ-025 SHALL, in DRAIN, deassert imem_req, discard each rvalid and decrement the stale count, then return to FETCH when the count reaches 0.
REQ-026 SHALL treat a branch during DRAIN as a retarget: the stale count is unchanged and the PC is updated.
REQ-027 SHALL discard an rvalid that coincides with branch=1.
REQ-028 SHALL assert misaligned for exactly the cycle after a branch with branch_address[1:0] != 0, and SHALL perform the redirect regardless.

Reset
REQ-029 SHALL, while rst_n=0, immediately force: fetch PC=RESET_PC, state=BOOT, counters=0, FIFO empty, imem_req=0, if_id_valid=0, if_id_pc=0, if_id_instr=32'h0000_0013 (NOP), misaligned=0.
REQ-030 SHALL ignore responses to requests in flight when reset is asserted mid-operation; the memory side is reset together with this block.

Structure
REQ-031 SHALL take RESET_PC's default, the NOP encoding and the FSM state encoding from the shared core package, alongside the existing ex_control field definitions.
REQ-032 SHALL instantiate the 2-entry FIFO as one sub-module, fetch_fifo (data+PC, push, pop, count); all other logic SHALL be inline.

Verification
REQ-033 SHALL be verified with the following directed scenarios:
- Reset release, imem_gnt=1, 1-cycle memory -> addresses 0,4,8,... with a back-to-back request every cycle, and if_id_pc following with 2-cycle lag.
- stall held 3 cycles during streaming -> if_id_* frozen, imem_req drops once 2 entries are buffered, and no instruction is lost or duplicated on release.
- branch=1 to 32'h0000_0100 with 2 requests outstanding -> DRAIN for 2 rvalids (both discarded), next imem_addr=32'h100, and if_id_valid=0 for that interval.
- branch coincident with grant and rvalid -> the rvalid is discarded, the granted request is counted stale, and the first delivered PC is the target.
- branch_address=32'h0000_0206 -> misaligned pulses 1 cycle, and the fetch resumes at 32'h204.
- Fetch from 32'hFFFF_FFFC -> next address 32'h0000_0000; rst_n asserted mid-stream -> outputs reach reset values with no clock edge.
